// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, bit positions and frame states for the UART transmitter
package uart_pkg;

  localparam logic [7:0] REG_TXDATA = 8'h00;
  localparam logic [7:0] REG_RXDATA = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h08;
  localparam logic [7:0] REG_CTRL   = 8'h0C;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 8;

  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_DIV_LSB = 16;
  localparam int CTRL_DIV_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - register-mapped 8N1 UART transmitter with TX FIFO and baud generator
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int               FIFO_DEPTH  = 8,
  parameter int               DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(868)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        tx_irq
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  tx_state_e                    state, state_d;
  logic [DIV_W-1:0]             baud_cnt, baud_d;
  logic [DIV_W-1:0]             eff_div, eff_div_d;
  logic [2:0]                   bit_cnt, bit_d;
  logic [7:0]                   shift, shift_d;
  logic                         tx_d;
  logic                         bit_end;
  logic                         start_frame;

  logic                         tx_en, irq_en, overflow;
  logic [DIV_W-1:0]             divisor;
  logic [CTRL_DIV_W-1:0]        div_cur, div_wr;

  logic                         wr_en, wr_txdata, wr_status, wr_ctrl;
  logic                         fifo_pop, fifo_full, fifo_empty;
  logic [7:0]                   fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         busy;
  logic [31:0]                  status_word, ctrl_word;
  logic                         unused_inputs;

  assign unused_inputs = ^{uart_rx, req_addr[31:8], req_wdata[15:8], req_wstrb[1]};

  assign wr_en     = req_valid && req_write;
  assign wr_txdata = wr_en && (req_addr[7:0] == REG_TXDATA) && req_wstrb[0];
  assign wr_status = wr_en && (req_addr[7:0] == REG_STATUS) && req_wstrb[0];
  assign wr_ctrl   = wr_en && (req_addr[7:0] == REG_CTRL);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_txdata),
    .wdata (req_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Divisor bytes are merged so a partial-strobe write keeps the untouched byte
  assign div_cur = CTRL_DIV_W'(divisor);
  assign div_wr  = {req_wstrb[3] ? req_wdata[31:24] : div_cur[15:8],
                    req_wstrb[2] ? req_wdata[23:16] : div_cur[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en    <= 1'b0;
      irq_en   <= 1'b0;
      divisor  <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl && req_wstrb[0]) begin
        tx_en  <= req_wdata[CTRL_TX_EN];
        irq_en <= req_wdata[CTRL_IRQ_EN];
      end
      if (wr_ctrl && |req_wstrb[3:2]) divisor <= DIV_W'(div_wr);
      if (wr_txdata && fifo_full && !fifo_pop) overflow <= 1'b1;
      else if (wr_status && req_wdata[STAT_OVF]) overflow <= 1'b0;
    end
  end

  assign busy    = (state != IDLE);
  assign bit_end = (baud_cnt == eff_div - DIV_ONE);

  always_comb begin
    state_d     = state;
    baud_d      = baud_cnt;
    bit_d       = bit_cnt;
    shift_d     = shift;
    eff_div_d   = eff_div;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;
    tx_d        = 1'b1;
    case (state)
      IDLE: begin
        if (tx_en && !fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_cnt + DIV_ONE;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_cnt == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_cnt + 3'd1;
            shift_d = {1'b0, shift[7:1]};
          end
        end else begin
          baud_d = baud_cnt + DIV_ONE;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (tx_en && !fifo_empty) start_frame = 1'b1;
          else                      state_d     = IDLE;
        end else begin
          baud_d = baud_cnt + DIV_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Back-to-back frames reload straight from STOP, so there is no idle gap
    if (start_frame) begin
      fifo_pop  = 1'b1;
      state_d   = START;
      baud_d    = '0;
      shift_d   = fifo_rdata;
      eff_div_d = (divisor == '0) ? DIV_ONE : divisor;
    end
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      eff_div  <= DIV_ONE;
      uart_tx  <= 1'b1;
      tx_irq   <= 1'b0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shift    <= shift_d;
      eff_div  <= eff_div_d;
      uart_tx  <= tx_d;
      tx_irq   <= irq_en && fifo_empty && (state == IDLE);
    end
  end

  always_comb begin
    status_word                                = '0;
    status_word[STAT_BUSY]                     = busy;
    status_word[STAT_FULL]                     = fifo_full;
    status_word[STAT_EMPTY]                    = fifo_empty;
    status_word[STAT_OVF]                      = overflow;
    status_word[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_count);
  end

  always_comb begin
    ctrl_word                               = '0;
    ctrl_word[CTRL_TX_EN]                   = tx_en;
    ctrl_word[CTRL_IRQ_EN]                  = irq_en;
    ctrl_word[CTRL_DIV_LSB +: CTRL_DIV_W]   = div_cur;
  end

  always_comb begin
    rdata = '0;
    case (req_addr[7:0])
      REG_STATUS: rdata = status_word;
      REG_CTRL:   rdata = ctrl_word;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata, rdata;
  logic [3:0]  req_wstrb;
  logic        uart_rx, uart_tx, tx_irq;
  int          checks = 0;
  int          failures = 0;
  int          n;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .FIFO_DEPTH  (8),
    .DIV_W       (16),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rdata     (rdata),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .tx_irq    (tx_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_wstrb = 4'h0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    req_addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  // Waits (bounded) for the start bit, then checks every bit level is held exactly div cycles
  task automatic frame(input string tag, input logic [7:0] b, input int div, input int exp_lat);
    logic [9:0] pat;
    int lat, match;
    pat = {1'b1, b, 1'b0};
    req_addr = 32'h08;
    #1;
    lat = 0;
    while (uart_tx !== 1'b0 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, {31'b0, rdata[0]}, 32'd1);
    chk({tag, "_irq_start"}, {31'b0, tx_irq}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      match = 0;
      for (int c = 0; c < div; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (uart_tx === pat[k]) match++;
      end
      chk($sformatf("%s_bit%0d", tag, k), match, div);
    end
    chk({tag, "_irq_end"}, {31'b0, tx_irq}, 32'd0);
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    uart_rx = 1'b1;

    // 1: reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    read_chk("rst_status", 32'h08, 32'h0000_0004);
    read_chk("rst_ctrl",   32'h0C, 32'h0364_0000);
    read_chk("rst_rxdata", 32'h04, 32'h0000_0000);
    read_chk("rst_txdata", 32'h00, 32'h0000_0000);
    read_chk("rst_other",  32'h10, 32'h0000_0000);
    chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_tx_irq",  {31'b0, tx_irq},  32'd0);

    // 2: single 0xA5 frame at div 4
    bus_write(32'h0C, 32'h0004_0001, 4'hF);
    read_chk("ctrl_rb", 32'h0C, 32'h0004_0001);
    bus_write(32'h00, 32'h0000_00A5, 4'h1);
    frame("fA5", 8'hA5, 4, 1);
    @(negedge clk);
    read_chk("a5_idle_status", 32'h08, 32'h0000_0004);
    chk("a5_idle_tx", {31'b0, uart_tx}, 32'd1);

    // 3: back-to-back pushes, no gap between frames
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h00; req_wdata = 32'h11; req_wstrb = 4'h1;
    @(negedge clk);
    req_wdata = 32'h22;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_wstrb = 4'h0;
    frame("f11", 8'h11, 4, 0);
    frame("f22", 8'h22, 4, 1);
    @(negedge clk);
    read_chk("b2b_idle_status", 32'h08, 32'h0000_0004);

    // 4: overflow, sticky clear, then drain exactly 8 frames
    bus_write(32'h0C, 32'h0004_0000, 4'hF);
    for (int i = 0; i < 9; i++) bus_write(32'h00, 32'h31 + i, 4'h1);
    read_chk("ovf_status", 32'h08, 32'h0000_080A);
    bus_write(32'h08, 32'h0000_0008, 4'h1);
    read_chk("ovf_clr_status", 32'h08, 32'h0000_0802);
    bus_write(32'h0C, 32'h0004_0001, 4'hF);
    for (int i = 0; i < 8; i++) frame($sformatf("drain%0d", i), 8'(8'h31 + i), 4, 1);
    @(negedge clk);
    read_chk("drain_status", 32'h08, 32'h0000_0004);

    // 5: tx_en cleared and divisor zeroed mid-frame
    bus_write(32'h0C, 32'h0004_0000, 4'hF);
    bus_write(32'h00, 32'h5A, 4'h1);
    bus_write(32'h00, 32'hC3, 4'h1);
    bus_write(32'h0C, 32'h0004_0001, 4'hF);
    repeat (6) @(negedge clk);
    bus_write(32'h0C, 32'h0000_0000, 4'hF);
    req_addr = 32'h08;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdata[0] !== 1'b0 && n < 200);
    chk("halt_frame_len", n, 33);
    chk("halt_tx_high", {31'b0, uart_tx}, 32'd1);
    repeat (20) @(negedge clk);
    chk("halt_tx_still_high", {31'b0, uart_tx}, 32'd1);
    read_chk("halt_status", 32'h08, 32'h0000_0100);
    bus_write(32'h0C, 32'h0000_0001, 4'hF);
    frame("fC3_div0", 8'hC3, 1, 1);
    @(negedge clk);
    read_chk("div0_idle_status", 32'h08, 32'h0000_0004);

    // 6: interrupt on return to idle, then reset mid-frame
    bus_write(32'h0C, 32'h0004_0000, 4'hF);
    bus_write(32'h00, 32'h81, 4'h1);
    bus_write(32'h0C, 32'h0004_0003, 4'hF);
    frame("f81", 8'h81, 4, 1);
    @(negedge clk);
    @(negedge clk);
    chk("irq_idle", {31'b0, tx_irq}, 32'd1);
    bus_write(32'h00, 32'h00, 4'h1);
    repeat (12) @(negedge clk);
    chk("pre_rst_tx_low", {31'b0, uart_tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_mid_irq", {31'b0, tx_irq}, 32'd0);
    read_chk("rst_mid_status", 32'h08, 32'h0000_0004);
    read_chk("rst_mid_ctrl", 32'h0C, 32'h0364_0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_tx", {31'b0, uart_tx}, 32'd1);
    read_chk("post_rst_status", 32'h08, 32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
